uart_wb_master: RTL and testbench

//  UART-to-Wishbone bridge master: the initiator end of the Wishbone link our UART peripheral responds on.

---
 rtl/uart_wb_master.sv | 178 +++++++++++++++++
 tb/tb_uart_wb_master.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_master.sv
// UART-to-Wishbone bridge master: parses 'W'/'R' command packets from the RX byte stream,
// runs one Wishbone classic cycle per packet and returns 'K', 'E' or read data on the TX byte stream.
module uart_wb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [7:0]                i_rx_data,
    input  logic                      i_rx_valid,
    output logic                      o_rx_ready,
    output logic [7:0]                o_tx_data,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready,
    output logic                      o_wb_cyc,
    output logic                      o_wb_stb,
    output logic                      o_wb_we,
    output logic [ADDR_WIDTH-1:0]     o_wb_addr,
    output logic [DATA_WIDTH-1:0]     o_wb_data,
    output logic [DATA_WIDTH/8-1:0]   o_wb_sel,
    input  logic                      i_wb_ack,
    input  logic                      i_wb_err,
    input  logic [DATA_WIDTH-1:0]     i_wb_data,
    output logic                      o_busy
);

    localparam int AB = ADDR_WIDTH / 8;
    localparam int DB = DATA_WIDTH / 8;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [7:0]    CMD_W    = 8'h57;
    localparam logic [7:0]    CMD_R    = 8'h52;
    localparam logic [7:0]    RSP_K    = 8'h4B;
    localparam logic [7:0]    RSP_E    = 8'h45;
    localparam logic [7:0]    AB_LAST  = 8'(AB - 1);
    localparam logic [7:0]    DB_LAST  = 8'(DB - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    state_t                  state_q;
    logic                    rx_ready_q;
    logic [7:0]              tx_data_q;
    logic                    tx_valid_q;
    logic                    cyc_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [7:0]              cnt_q;
    logic [TW-1:0]           tmo_q;

    logic rx_fire;
    assign rx_fire = i_rx_valid && rx_ready_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b1;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Unknown command bytes are popped and dropped here.
                    if (rx_fire && (i_rx_data == CMD_W || i_rx_data == CMD_R)) begin
                        we_q    <= (i_rx_data == CMD_W);
                        cnt_q   <= '0;
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (rx_fire) begin
                        addr_q <= (addr_q << 8) | ADDR_WIDTH'(i_rx_data);
                        if (cnt_q == AB_LAST) begin
                            cnt_q <= '0;
                            if (we_q) begin
                                state_q <= S_DATA;
                            end else begin
                                state_q    <= S_BUS;
                                cyc_q      <= 1'b1;
                                rx_ready_q <= 1'b0;
                                tmo_q      <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_fire) begin
                        wdata_q <= (wdata_q << 8) | DATA_WIDTH'(i_rx_data);
                        if (cnt_q == DB_LAST) begin
                            cnt_q      <= '0;
                            state_q    <= S_BUS;
                            cyc_q      <= 1'b1;
                            rx_ready_q <= 1'b0;
                            tmo_q      <= '0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                S_BUS: begin
                    // err beats a simultaneous ack; timeout only fires with neither present.
                    if (i_wb_err || (!i_wb_ack && tmo_q == TMO_LAST)) begin
                        cyc_q      <= 1'b0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= RSP_E;
                        cnt_q      <= '0;
                        state_q    <= S_RESP;
                    end else if (i_wb_ack) begin
                        cyc_q      <= 1'b0;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_RESP;
                        if (we_q) begin
                            tx_data_q <= RSP_K;
                            cnt_q     <= '0;
                        end else begin
                            tx_data_q <= i_wb_data[DATA_WIDTH-1 -: 8];
                            rdata_q   <= i_wb_data << 8;
                            cnt_q     <= DB_LAST;
                        end
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_RESP: begin
                    // cnt_q holds the number of response bytes still to follow the current one.
                    if (i_tx_ready) begin
                        if (cnt_q == 8'd0) begin
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= '0;
                            rx_ready_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end else begin
                            cnt_q     <= cnt_q - 8'd1;
                            tx_data_q <= rdata_q[DATA_WIDTH-1 -: 8];
                            rdata_q   <= rdata_q << 8;
                        end
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    rx_ready_q <= 1'b1;
                    tx_valid_q <= 1'b0;
                    cyc_q      <= 1'b0;
                end
            endcase
        end
    end

    assign o_rx_ready = rx_ready_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_wb_cyc   = cyc_q;
    assign o_wb_stb   = cyc_q;
    assign o_wb_we    = we_q;
    assign o_wb_addr  = addr_q;
    assign o_wb_data  = wdata_q;
    assign o_wb_sel   = {DB{cyc_q}};
    assign o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed bench for uart_wb_master: RX byte queue driver, TX byte sink, scripted Wishbone slave.
module tb_uart_wb_master;

    localparam int TMO = 16;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_addr;
    logic [31:0] wb_wdata;
    logic [3:0]  wb_sel;
    logic        wb_ack;
    logic        wb_err;
    logic [31:0] wb_rdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  got_q[$];
    logic [31:0] log_addr[$];
    logic        log_we[$];
    logic [31:0] log_data[$];
    logic [3:0]  log_sel[$];
    int          cyc_cnt;

    // slave script: mode 0 = never respond, 1 = ack, 2 = err; responds after slv_wait cycles
    int slv_mode;
    int slv_wait;
    int slv_cnt;

    uart_wb_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_rx_data(rx_data),
        .i_rx_valid(rx_valid),
        .o_rx_ready(rx_ready),
        .o_tx_data(tx_data),
        .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready),
        .o_wb_cyc(wb_cyc),
        .o_wb_stb(wb_stb),
        .o_wb_we(wb_we),
        .o_wb_addr(wb_addr),
        .o_wb_data(wb_wdata),
        .o_wb_sel(wb_sel),
        .i_wb_ack(wb_ack),
        .i_wb_err(wb_err),
        .i_wb_data(wb_rdata),
        .o_busy(busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // RX source and Wishbone slave drive on the falling edge
    always @(negedge clk) begin
        rx_valid = (rx_q.size() > 0);
        rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        if (wb_cyc) begin
            if (slv_cnt >= slv_wait) begin
                wb_ack = (slv_mode == 1);
                wb_err = (slv_mode == 2);
            end else begin
                wb_ack = 1'b0;
                wb_err = 1'b0;
            end
            slv_cnt++;
        end else begin
            wb_ack  = 1'b0;
            wb_err  = 1'b0;
            slv_cnt = 0;
        end
    end

    // Monitor: handshakes and bus cycles as seen by the DUT at the rising edge
    always @(posedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready && rx_q.size() > 0) void'(rx_q.pop_front());
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (wb_cyc) cyc_cnt++;
            if (wb_cyc && (wb_ack || wb_err)) begin
                log_addr.push_back(wb_addr);
                log_we.push_back(wb_we);
                log_data.push_back(wb_wdata);
                log_sel.push_back(wb_sel);
            end
        end
    end

    // driver tasks
    task automatic clear_logs();
        rx_q.delete();
        got_q.delete();
        log_addr.delete();
        log_we.delete();
        log_data.delete();
        log_sel.delete();
        cyc_cnt = 0;
    endtask

    task automatic load(input logic [71:0] pkt, input int n);
        for (int i = n - 1; i >= 0; i--) rx_q.push_back(pkt[i*8 +: 8]);
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (got_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pad_logs(input int n);
        while (got_q.size() < 8) got_q.push_back(8'h00);
        while (log_addr.size() < n) begin
            log_addr.push_back('0);
            log_we.push_back(1'b0);
            log_data.push_back('0);
            log_sel.push_back('0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin errors++; $display("FAIL reset_cyc_stb: got %b%b want 00", wb_cyc, wb_stb); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (wb_sel !== 4'h0) begin errors++; $display("FAIL reset_sel: got %h want 0", wb_sel); end
        checks++; if (wb_addr !== 32'h0 || wb_wdata !== 32'h0 || wb_we !== 1'b0) begin
            errors++; $display("FAIL reset_bus_regs: addr %h data %h we %b want zeros", wb_addr, wb_wdata, wb_we);
        end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        bit ok;
        clear_logs();
        slv_mode = 1; slv_wait = 2;
        load(72'h57_00001004_DEADBEEF, 9);
        wait_got(1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL write_timeout: got %0d bytes want 1", got_q.size()); end
        checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL write_cycles: got %0d want 1", log_addr.size()); end
        pad_logs(1);
        checks++; if (got_q[0] !== 8'h4B) begin errors++; $display("FAIL write_resp: got %h want 4b", got_q[0]); end
        checks++; if (log_addr[0] !== 32'h00001004) begin errors++; $display("FAIL write_addr: got %h want 00001004", log_addr[0]); end
        checks++; if (log_we[0] !== 1'b1) begin errors++; $display("FAIL write_we: got %b want 1", log_we[0]); end
        checks++; if (log_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL write_data: got %h want deadbeef", log_data[0]); end
        checks++; if (log_sel[0] !== 4'hF) begin errors++; $display("FAIL write_sel: got %h want f", log_sel[0]); end
        checks++; if (cyc_cnt !== 3) begin errors++; $display("FAIL write_cyc_len: got %0d want 3", cyc_cnt); end
        checks++; if (busy !== 1'b0 || rx_ready !== 1'b1) begin errors++; $display("FAIL write_idle: busy %b rx_ready %b want 0 1", busy, rx_ready); end
        checks++; if (wb_sel !== 4'h0) begin errors++; $display("FAIL write_sel_idle: got %h want 0", wb_sel); end
    endtask

    task automatic test_read();
        bit ok;
        clear_logs();
        slv_mode = 1; slv_wait = 0; wb_rdata = 32'h12345678;
        load(72'h52_00000020, 5);
        wait_got(4, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL read_timeout: got %0d bytes want 4", got_q.size()); end
        pad_logs(1);
        checks++; if ({got_q[0], got_q[1], got_q[2], got_q[3]} !== 32'h12345678) begin
            errors++; $display("FAIL read_resp: got %h%h%h%h want 12345678", got_q[0], got_q[1], got_q[2], got_q[3]);
        end
        checks++; if (cyc_cnt !== 1) begin errors++; $display("FAIL read_cyc_len: got %0d want 1", cyc_cnt); end
        checks++; if (log_addr[0] !== 32'h20 || log_we[0] !== 1'b0) begin
            errors++; $display("FAIL read_cycle: addr %h we %b want 00000020 0", log_addr[0], log_we[0]);
        end
    endtask

    task automatic test_error();
        bit ok;
        clear_logs();
        slv_mode = 2; slv_wait = 1;
        load(72'h52_00000024, 5);
        wait_got(1, 200, ok);
        repeat (3) @(negedge clk);
        checks++; if (!ok || got_q.size() !== 1) begin errors++; $display("FAIL err_count: got %0d bytes want 1", got_q.size()); end
        pad_logs(1);
        checks++; if (got_q[0] !== 8'h45) begin errors++; $display("FAIL err_resp: got %h want 45", got_q[0]); end
        checks++; if (cyc_cnt !== 2) begin errors++; $display("FAIL err_cyc_len: got %0d want 2", cyc_cnt); end
    endtask

    task automatic test_timeout();
        bit ok;
        clear_logs();
        slv_mode = 0; slv_wait = 0;
        load(72'h52_00000028, 5);
        wait_got(1, TMO + 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_wait: got %0d bytes want 1", got_q.size()); end
        pad_logs(0);
        checks++; if (got_q[0] !== 8'h45) begin errors++; $display("FAIL tmo_resp: got %h want 45", got_q[0]); end
        checks++; if (cyc_cnt !== TMO) begin errors++; $display("FAIL tmo_cyc_len: got %0d want %0d", cyc_cnt, TMO); end
    endtask

    task automatic test_junk_backpressure();
        bit ok;
        clear_logs();
        slv_mode = 1; slv_wait = 0; wb_rdata = 32'hA1B2C3D4;
        tx_ready = 1'b0;
        load(72'h00FF_52_00000030, 7);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_valid) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL junk_tx_valid: got %b want 1", tx_valid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA1) begin
                errors++; $display("FAIL bp_hold: valid %b data %h want 1 a1", tx_valid, tx_data);
            end
        end
        tx_ready = 1'b1;
        wait_got(4, 100, ok);
        repeat (4) @(negedge clk);
        checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d bytes want 4", got_q.size()); end
        checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL junk_cycles: got %0d want 1", log_addr.size()); end
        pad_logs(1);
        checks++; if ({got_q[0], got_q[1], got_q[2], got_q[3]} !== 32'hA1B2C3D4) begin
            errors++; $display("FAIL bp_bytes: got %h%h%h%h want a1b2c3d4", got_q[0], got_q[1], got_q[2], got_q[3]);
        end
        checks++; if (log_addr[0] !== 32'h30) begin errors++; $display("FAIL junk_addr: got %h want 00000030", log_addr[0]); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_logs();
        slv_mode = 1; slv_wait = 0; wb_rdata = 32'hCAFEF00D;
        load(72'h57_00000100_11223344, 9);
        load(72'h52_00000104, 5);
        wait_got(5, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_wait: got %0d bytes want 5", got_q.size()); end
        checks++; if (log_addr.size() !== 2) begin errors++; $display("FAIL b2b_cycles: got %0d want 2", log_addr.size()); end
        pad_logs(2);
        checks++; if (got_q[0] !== 8'h4B) begin errors++; $display("FAIL b2b_first: got %h want 4b", got_q[0]); end
        checks++; if ({got_q[1], got_q[2], got_q[3], got_q[4]} !== 32'hCAFEF00D) begin
            errors++; $display("FAIL b2b_read: got %h%h%h%h want cafef00d", got_q[1], got_q[2], got_q[3], got_q[4]);
        end
        checks++; if (log_addr[0] !== 32'h100 || log_we[0] !== 1'b1 || log_data[0] !== 32'h11223344) begin
            errors++; $display("FAIL b2b_wr_cycle: addr %h we %b data %h want 00000100 1 11223344", log_addr[0], log_we[0], log_data[0]);
        end
        checks++; if (log_addr[1] !== 32'h104 || log_we[1] !== 1'b0) begin
            errors++; $display("FAIL b2b_rd_cycle: addr %h we %b want 00000104 0", log_addr[1], log_we[1]);
        end
    endtask

    task automatic test_reset_mid_bus();
        bit ok;
        clear_logs();
        slv_mode = 0; slv_wait = 0;
        load(72'h52_00000040, 5);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wb_cyc) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rst_bus_cyc: got %b want 1", wb_cyc); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin errors++; $display("FAIL rst_async_cyc: got %b%b want 00", wb_cyc, wb_stb); end
        checks++; if (busy !== 1'b0 || rx_ready !== 1'b1) begin errors++; $display("FAIL rst_async_state: busy %b rx_ready %b want 0 1", busy, rx_ready); end
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        slv_mode = 1; slv_wait = 0;
        load(72'h57_00000044_01020304, 9);
        wait_got(1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_recover_wait: got %0d bytes want 1", got_q.size()); end
        pad_logs(1);
        checks++; if (got_q[0] !== 8'h4B) begin errors++; $display("FAIL rst_recover_resp: got %h want 4b", got_q[0]); end
        checks++; if (log_addr[0] !== 32'h44 || log_data[0] !== 32'h01020304) begin
            errors++; $display("FAIL rst_recover_cycle: addr %h data %h want 00000044 01020304", log_addr[0], log_data[0]);
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_rdata = 32'h0;
        slv_mode = 0;
        slv_wait = 0;
        slv_cnt  = 0;
        cyc_cnt  = 0;
        test_reset();
        test_write();
        test_read();
        test_error();
        test_timeout();
        test_junk_backpressure();
        test_back_to_back();
        test_reset_mid_bus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
